pc_fetch_unit: RTL

//   Instruction fetch stage feeding CCG1. Holds the program counter and drives
//   the instruction-memory address. Returns the fetched 16-bit segment and the

---
 rtl/pc_fetch_unit.sv | 67 ++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: program counter, redirect target selection and
// wrong-path squashing of the words fetched after a taken redirect.
module pc_fetch_unit #(
    parameter int                 PC_W        = 8,
    parameter int                 INSTR_W     = 16,
    parameter int                 FLUSH_DEPTH = 2,
    parameter logic [PC_W-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_W-1:0] NOP_WORD    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               L_PC,
    input  logic               S11,
    input  logic               S10,
    input  logic [PC_W-1:0]    od_addr,
    input  logic [PC_W-1:0]    dm_addr,
    input  logic [PC_W-1:0]    reg_addr,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] segment,
    output logic [PC_W-1:0]    PC_in,
    output logic               squash
);

    localparam logic [1:0] FLUSH_CNT = 2'(FLUSH_DEPTH);

    logic [PC_W-1:0] pc_p0;
    logic [1:0]      sq_cnt_p0;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;

    always_comb begin
        pc_inc = pc_p0 + PC_W'(1);
        target = pc_inc;
        case ({S11, S10})
            2'b00:   target = pc_inc;
            2'b01:   target = od_addr;
            2'b10:   target = dm_addr;
            default: target = reg_addr;
        endcase
    end

    // Stage p0: PC and squash counter; a redirect overrides stall and reloads the flush window
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0     <= RESET_PC;
            sq_cnt_p0 <= 2'd0;
        end else if (L_PC) begin
            pc_p0     <= target;
            sq_cnt_p0 <= FLUSH_CNT;
        end else if (!stall) begin
            pc_p0 <= pc_inc;
            if (sq_cnt_p0 != 2'd0)
                sq_cnt_p0 <= sq_cnt_p0 - 2'd1;
        end
    end

    // Outputs are unregistered here; the next stage captures them
    always_comb begin
        imem_addr = pc_p0;
        PC_in     = pc_inc;
        squash    = (sq_cnt_p0 != 2'd0);
        segment   = squash ? NOP_WORD : imem_data;
    end

endmodule
